// File: rtl/regfile_pkg.sv
// regfile_pkg -- shared defaults for the register file with scoreboard.
//   REGFILE_W      : default data width in bits
//   REGFILE_DEPTH  : default register count (power of two, >= 4)
//   link_index()   : register that receives link writes (last register)
package regfile_pkg;

  localparam int unsigned REGFILE_W     = 32;
  localparam int unsigned REGFILE_DEPTH = 32;

  // The link register is always the highest-numbered register.
  function automatic int unsigned link_index(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard -- per-register busy bits for the register file.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle clear forwarding).
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   set_en/set_addr       : mark a destination busy at issue
//   clr_en/clr_addr       : clear busy on load write-back
//   rr1/rr2               : read addresses
//   busy1/busy2           : combinational busy status of rr1/rr2
module regfile_scoreboard #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  output logic          busy1,
  output logic          busy2
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // Set is applied after clear so a new producer issued in the same cycle
  // as the old producer's write-back keeps the register busy.
  // Register 0 is never set, so it reads as not busy forever.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && (set_addr != '0)) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) busy_q <= '0;
    else       busy_q <= busy_d;
  end

  always_comb begin
    busy1 = busy_q[rr1];
    busy2 = busy_q[rr2];
`ifdef REGFILE_BYPASS_EN
    // A write-back landing this cycle already satisfies the reader,
    // unless a new producer claims the same register in the same cycle.
    if (clr_en && (clr_addr == rr1) && !(set_en && (set_addr == rr1))) busy1 = 1'b0;
    if (clr_en && (clr_addr == rr2) && !(set_en && (set_addr == rr2))) busy2 = 1'b0;
`endif
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb -- two-write / two-read register file with busy scoreboard.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding).
// Ports:
//   clock, reset                  : clock, synchronous active-high reset
//   wa_en/wa_addr/wa_data         : ALU write-back port A
//   link_en                       : redirect a port-A write to register DEPTH-1
//   wb_en/wb_addr/wb_data         : load write-back port B (also clears busy)
//   sb_set_en/sb_set_addr         : mark destination busy at issue
//   rr1/rr2, rdata1/rdata2        : combinational read ports
//   busy1/busy2                   : combinational busy status of rr1/rr2
//   conflict                      : registered pulse, A and B hit the same
//                                   nonzero register in the previous cycle
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned W     = REGFILE_W,
  parameter int unsigned DEPTH = REGFILE_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [W-1:0]  wa_data,
  input  logic          link_en,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [W-1:0]  wb_data,
  input  logic          sb_set_en,
  input  logic [AW-1:0] sb_set_addr,
  input  logic [AW-1:0] rr1,
  input  logic [AW-1:0] rr2,
  output logic [W-1:0]  rdata1,
  output logic [W-1:0]  rdata2,
  output logic          busy1,
  output logic          busy2,
  output logic          conflict
);

  localparam logic [AW-1:0] LINK_ADDR = AW'(link_index(DEPTH));

  logic [W-1:0]  regs_q [DEPTH];
  logic [W-1:0]  regs_d [DEPTH];
  logic          conflict_q;
  logic          conflict_d;
  logic [AW-1:0] a_addr;

  assign a_addr = link_en ? LINK_ADDR : wa_addr;

  // Port B is applied last so it wins a same-address collision.
  // Register 0 is never written, so it stays zero after reset.
  always_comb begin
    regs_d = regs_q;
    if (wa_en && (a_addr != '0))  regs_d[a_addr]  = wa_data;
    if (wb_en && (wb_addr != '0)) regs_d[wb_addr] = wb_data;
  end

  assign conflict_d = wa_en && wb_en && (a_addr == wb_addr) && (wb_addr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) regs_q[i] <= '0;
      conflict_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      conflict_q <= conflict_d;
    end
  end

  assign conflict = conflict_q;

  always_comb begin
    rdata1 = regs_q[rr1];
    rdata2 = regs_q[rr2];
`ifdef REGFILE_BYPASS_EN
    // Forward data being written this cycle; B beats A beats the array.
    if (rr1 != '0) begin
      if (wb_en && (wb_addr == rr1))     rdata1 = wb_data;
      else if (wa_en && (a_addr == rr1)) rdata1 = wa_data;
    end
    if (rr2 != '0) begin
      if (wb_en && (wb_addr == rr2))     rdata2 = wb_data;
      else if (wa_en && (a_addr == rr2)) rdata2 = wa_data;
    end
`endif
  end

  regfile_scoreboard #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_scoreboard (
    .clock    (clock),
    .reset    (reset),
    .set_en   (sb_set_en),
    .set_addr (sb_set_addr),
    .clr_en   (wb_en),
    .clr_addr (wb_addr),
    .rr1      (rr1),
    .rr2      (rr2),
    .busy1    (busy1),
    .busy2    (busy2)
  );

endmodule
